raster_timing_gen: RTL and testbench
====================================

Name: raster_timing_gen

Overview:
Upstream neighbour of conv_kernel and RGB_Process. Accepts a ready/valid pixel stream, for example from image_loader or a camera capture FIFO. Re-times that stream into a continuous VGA-style raster: active pixels, front porch, sync and back porch, with active-low vs/hs/blank and row/col counters. Runs one pixel per clk. Inserts blanking, so downstream line-buffer stages see true raster timing.

Parameters:
- WIDTH, 640: active pixels per line.
- HEIGHT, 480: active lines per frame.
- H_FP / H_SYNC / H_BP, 16 / 96 / 48: horizontal porch and sync lengths in clocks, each ≥1.
- V_FP / V_SYNC / V_BP, 10 / 2 / 33: vertical porch and sync lengths in lines, each ≥1.
- PIXEL_DEPTH, 8: bits per colour channel.
- CNT_WIDTH, 13: width of the row/col/counter outputs.

Ports:
- clk, in, 1: pixel clock.
- reset, in, 1: synchronous, active-high reset.
- in_valid, in, 1: upstream pixel valid.
- in_ready, out, 1: pixel accepted when in_valid && in_ready.
- in_sof, in, 1: marks the first pixel of a frame.
- in_R / in_G / in_B, in, PIXEL_DEPTH: input pixel.
- vs_no / hs_no / blank_no, out, 1: active-low sync and blank outputs; blank_no=1 means active video.
- output_R / output_G / output_B, out, PIXEL_DEPTH: raster pixel; 0 outside active video.
- row / col, out, CNT_WIDTH: raster position of the current output.
- underflow, out, 1: sticky; active slot found no input pixel.
- sof_err, out, 1: sticky; in_sof arrived at the wrong position.
- clear_err, in, 1: clears both sticky flags.

Behaviour:
- Geometry:
  - H_TOTAL = WIDTH+H_FP+H_SYNC+H_BP.
  - V_TOTAL = HEIGHT+V_FP+V_SYNC+V_BP.
  - h counts 0..H_TOTAL-1 and wraps to 0, advancing v.
  - v wraps from V_TOTAL-1 to 0.
  - Counters free-run every cycle once out of reset.
- Timing signals:
  - active = (h<WIDTH) && (v<HEIGHT).
  - hs low for h in [WIDTH+H_FP, WIDTH+H_FP+H_SYNC).
  - vs low for v in [HEIGHT+V_FP, HEIGHT+V_FP+V_SYNC), for the whole line.
- Output timing:
  - All outputs are registered.
  - Outputs at cycle t+1 reflect counter position (h,v) and the pixel accepted at cycle t.
  - Latency from input handshake to output pixel is 1 clk.
  - row/col equal v/h at that position.
  - At the zero position, row and col are both 0.
- Reset values:
  - h=v=0; state WAIT_SOF.
  - vs_no=hs_no=1, blank_no=0.
  - RGB=0, row=col=0.
  - in_ready=0, underflow=sof_err=0.
- FSM, state WAIT_SOF:
  - Outputs follow raster timing with blank_no=0 and RGB=0.
  - in_ready = in_valid && !in_sof, which drains pixels up to the next frame start.
  - Moves to RUN only on a cycle where (h,v)=(H_TOTAL-1,V_TOTAL-1) and in_valid && in_sof.
- FSM, state RUN:
  - in_ready = active.
  - Active slot with in_valid=1: emit the input pixel.
  - Active slot with in_valid=0: emit a 0 fill pixel, set underflow. No pixel is consumed and raster timing never stalls.
  - A head pixel with in_sof=1 at an active slot other than (0,0): not consumed; set sof_err; go to WAIT_SOF. Remaining active slots of the frame emit blank_no=0 and 0 RGB.
  - At (0,0), in_sof=0 is tolerated: the pixel is emitted and no error is raised.
- Sticky flags:
  - clear_err clears both flags.
  - If clear_err coincides with a new error event, the set wins.
- Reset mid-frame: all state returns to reset values on the next edge.
- Counter comparisons use CNT_WIDTH unsigned arithmetic; CNT_WIDTH must hold H_TOTAL-1 and V_TOTAL-1.

Optional Feature:
RASTER_TEST_PATTERN_EN.
- When defined: adds input pattern_en (1 bit).
  - While pattern_en=1 in RUN, in_ready=0 and active output is 8 vertical colour bars.
  - Bar index = col*8/WIDTH, in order: white, yellow, cyan, green, magenta, red, blue, black. Channels are all-ones or 0.
  - underflow is not set while the pattern is shown.
- When undefined: no pattern_en port and no bar logic.

Decomposition:
- Package raster_pkg holds:
  - state enum {WAIT_SOF, RUN};
  - a localparam function computing H_TOTAL and V_TOTAL;
  - an rgb_t struct (R, G, B of PIXEL_DEPTH).
- One natural sub-module: raster_counter, holding the h/v counters, wrap logic and the active/hs/vs decode. The top module keeps the FSM, handshake and pixel mux.

Test Plan:
All scenarios use WIDTH=4, HEIGHT=2, H_FP=1, H_SYNC=2, H_BP=1, V_FP=V_SYNC=V_BP=1, giving H_TOTAL=8 and V_TOTAL=5.
1. Reset, then hold in_valid=0 → blank_no=0 throughout. hs_no low for h=5,6 of every line. vs_no low for all of line 3. Period is 40 clks.
2. Stream pixel values 1..8 with in_sof on the first, always valid → lock at the frame boundary. Row 0 outputs 1,2,3,4 and row 1 outputs 5,6,7,8, each with blank_no=1. in_ready=1 only in active slots. No flags set.
3. In RUN, drop in_valid for active slot (row 1, col 2) → that output is 0 with blank_no=1 and underflow=1. The next input pixel appears at col 3. Pulse clear_err → underflow=0.
4. Assert in_sof on the pixel at (row 0, col 2) → sof_err=1. State becomes WAIT_SOF and output is blanked for the rest of the frame. Relock happens at the next boundary given an in_sof pixel.
5. Assert reset at (row 1, col 1) → next cycle all outputs at reset values, h=v=0, in_ready=0.
6. With RASTER_TEST_PATTERN_EN and pattern_en=1 → in_ready stays 0. Active outputs are the bar colours for cols 0..3 (white, cyan, magenta, blue).

Source files
------------

// File: rtl/raster_pkg.sv
// raster_pkg: shared types and helpers for the raster timing generator.
//   state_t      : framing FSM state (WAIT_SOF, RUN)
//   rgb_t        : one RGB pixel at the default 8-bit channel depth
//   raster_total : active + porch + sync length, used for H_TOTAL / V_TOTAL
package raster_pkg;

  typedef enum logic [0:0] {
    WAIT_SOF = 1'b0,
    RUN      = 1'b1
  } state_t;

  localparam int RGB_DEPTH = 8;

  typedef struct packed {
    logic [RGB_DEPTH-1:0] r;
    logic [RGB_DEPTH-1:0] g;
    logic [RGB_DEPTH-1:0] b;
  } rgb_t;

  function automatic int raster_total(input int active, input int fp,
                                      input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/raster_counter.sv
// raster_counter: free-running h/v raster counters with timing decode.
// Ports:
//   clk, reset       : pixel clock, synchronous active-high reset
//   h, v             : current raster position (CNT_WIDTH unsigned)
//   active           : h < WIDTH && v < HEIGHT
//   hs_act / vs_act  : horizontal / vertical sync interval (active-high here)
//   at_last          : position is (H_TOTAL-1, V_TOTAL-1), the frame boundary
//   at_zero          : position is (0, 0)
module raster_counter
  import raster_pkg::*;
#(
  parameter int WIDTH     = 640,
  parameter int HEIGHT    = 480,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter int CNT_WIDTH = 13
) (
  input  logic                 clk,
  input  logic                 reset,
  output logic [CNT_WIDTH-1:0] h,
  output logic [CNT_WIDTH-1:0] v,
  output logic                 active,
  output logic                 hs_act,
  output logic                 vs_act,
  output logic                 at_last,
  output logic                 at_zero
);

  localparam logic [CNT_WIDTH-1:0] H_LAST =
    CNT_WIDTH'(raster_total(WIDTH, H_FP, H_SYNC, H_BP) - 1);
  localparam logic [CNT_WIDTH-1:0] V_LAST =
    CNT_WIDTH'(raster_total(HEIGHT, V_FP, V_SYNC, V_BP) - 1);
  localparam logic [CNT_WIDTH-1:0] H_ACT    = CNT_WIDTH'(WIDTH);
  localparam logic [CNT_WIDTH-1:0] V_ACT    = CNT_WIDTH'(HEIGHT);
  localparam logic [CNT_WIDTH-1:0] HS_START = CNT_WIDTH'(WIDTH + H_FP);
  localparam logic [CNT_WIDTH-1:0] HS_END   = CNT_WIDTH'(WIDTH + H_FP + H_SYNC);
  localparam logic [CNT_WIDTH-1:0] VS_START = CNT_WIDTH'(HEIGHT + V_FP);
  localparam logic [CNT_WIDTH-1:0] VS_END   = CNT_WIDTH'(HEIGHT + V_FP + V_SYNC);

  logic [CNT_WIDTH-1:0] h_q, h_d;
  logic [CNT_WIDTH-1:0] v_q, v_d;

  always_comb begin
    h_d = h_q + CNT_WIDTH'(1);
    v_d = v_q;
    if (h_q == H_LAST) begin
      h_d = '0;
      v_d = (v_q == V_LAST) ? '0 : v_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      h_q <= '0;
      v_q <= '0;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
    end
  end

  assign h       = h_q;
  assign v       = v_q;
  assign active  = (h_q < H_ACT) && (v_q < V_ACT);
  assign hs_act  = (h_q >= HS_START) && (h_q < HS_END);
  assign vs_act  = (v_q >= VS_START) && (v_q < VS_END);
  assign at_last = (h_q == H_LAST) && (v_q == V_LAST);
  assign at_zero = (h_q == '0) && (v_q == '0);

endmodule

// File: rtl/raster_timing_gen.sv
// raster_timing_gen: re-times a ready/valid pixel stream into a continuous
// VGA-style raster with blanking, syncs and row/col positions.
// Optional feature macro: RASTER_TEST_PATTERN_EN (adds pattern_en and an
// 8-bar colour test pattern).
// Handshake: a pixel transfers on a cycle where in_valid && in_ready. in_ready
//   is a combinational decision for the current raster slot and never depends
//   on the pixel data; the raster itself never stalls.
// Ports:
//   clk, reset                 : pixel clock, synchronous active-high reset
//   in_valid/in_ready/in_sof   : input stream handshake and frame-start marker
//   in_R/in_G/in_B             : input pixel
//   vs_no/hs_no/blank_no       : registered active-low sync / blank
//   output_R/G/B               : registered raster pixel (0 outside active)
//   row/col                    : registered raster position of the outputs
//   underflow/sof_err          : sticky error flags, cleared by clear_err
//   state_dbg                  : current framing FSM state
//   pattern_en                 : (RASTER_TEST_PATTERN_EN only) show colour bars
module raster_timing_gen
  import raster_pkg::*;
#(
  parameter int WIDTH       = 640,
  parameter int HEIGHT      = 480,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter int PIXEL_DEPTH = 8,
  parameter int CNT_WIDTH   = 13
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_sof,
  input  logic [PIXEL_DEPTH-1:0] in_R,
  input  logic [PIXEL_DEPTH-1:0] in_G,
  input  logic [PIXEL_DEPTH-1:0] in_B,
`ifdef RASTER_TEST_PATTERN_EN
  input  logic                   pattern_en,
`endif
  output logic                   vs_no,
  output logic                   hs_no,
  output logic                   blank_no,
  output logic [PIXEL_DEPTH-1:0] output_R,
  output logic [PIXEL_DEPTH-1:0] output_G,
  output logic [PIXEL_DEPTH-1:0] output_B,
  output logic [CNT_WIDTH-1:0]   row,
  output logic [CNT_WIDTH-1:0]   col,
  output logic                   underflow,
  output logic                   sof_err,
  input  logic                   clear_err,
  output state_t                 state_dbg
);

  logic [CNT_WIDTH-1:0] h, v;
  logic active, hs_act, vs_act, at_last, at_zero;

  raster_counter #(
    .WIDTH(WIDTH), .HEIGHT(HEIGHT),
    .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .CNT_WIDTH(CNT_WIDTH)
  ) u_counter (
    .clk(clk), .reset(reset),
    .h(h), .v(v),
    .active(active), .hs_act(hs_act), .vs_act(vs_act),
    .at_last(at_last), .at_zero(at_zero)
  );

`ifdef RASTER_TEST_PATTERN_EN
  // Bar index = col*8/WIDTH; only meaningful in active slots (col < WIDTH).
  logic [2:0] bar_idx;
  assign bar_idx = 3'(({h, 3'b000}) / (CNT_WIDTH+3)'(WIDTH));
`endif

  state_t                 state_q, state_d;
  logic                   vs_no_q, vs_no_d;
  logic                   hs_no_q, hs_no_d;
  logic                   blank_no_q, blank_no_d;
  logic [PIXEL_DEPTH-1:0] r_q, r_d, g_q, g_d, b_q, b_d;
  logic [CNT_WIDTH-1:0]   row_q, row_d, col_q, col_d;
  logic                   underflow_q, underflow_d;
  logic                   sof_err_q, sof_err_d;
  logic                   ready_c, uf_set, sof_set;

  always_comb begin
    state_d    = state_q;
    ready_c    = 1'b0;
    blank_no_d = 1'b0;
    r_d        = '0;
    g_d        = '0;
    b_d        = '0;
    uf_set     = 1'b0;
    sof_set    = 1'b0;
    vs_no_d    = !vs_act;
    hs_no_d    = !hs_act;
    row_d      = v;
    col_d      = h;

    case (state_q)
      WAIT_SOF: begin
        // Drain everything up to (not including) the next frame head.
        ready_c = in_valid && !in_sof;
        if (at_last && in_valid && in_sof) state_d = RUN;
      end
      RUN: begin
        if (active) begin
`ifdef RASTER_TEST_PATTERN_EN
          if (pattern_en) begin
            blank_no_d = 1'b1;
            r_d = {PIXEL_DEPTH{!bar_idx[1]}};
            g_d = {PIXEL_DEPTH{!bar_idx[2]}};
            b_d = {PIXEL_DEPTH{!bar_idx[0]}};
          end else
`endif
          if (!in_valid) begin
            // Fill slot: raster keeps running, nothing consumed.
            ready_c    = 1'b1;
            blank_no_d = 1'b1;
            uf_set     = 1'b1;
          end else if (in_sof && !at_zero) begin
            // Misplaced frame head: leave it queued for the next boundary.
            sof_set = 1'b1;
            state_d = WAIT_SOF;
          end else begin
            ready_c    = 1'b1;
            blank_no_d = 1'b1;
            r_d        = in_R;
            g_d        = in_G;
            b_d        = in_B;
          end
        end
      end
      default: state_d = WAIT_SOF;
    endcase

    // A new error event wins over a coincident clear.
    underflow_d = uf_set  || (underflow_q && !clear_err);
    sof_err_d   = sof_set || (sof_err_q   && !clear_err);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= WAIT_SOF;
      vs_no_q     <= 1'b1;
      hs_no_q     <= 1'b1;
      blank_no_q  <= 1'b0;
      r_q         <= '0;
      g_q         <= '0;
      b_q         <= '0;
      row_q       <= '0;
      col_q       <= '0;
      underflow_q <= 1'b0;
      sof_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      vs_no_q     <= vs_no_d;
      hs_no_q     <= hs_no_d;
      blank_no_q  <= blank_no_d;
      r_q         <= r_d;
      g_q         <= g_d;
      b_q         <= b_d;
      row_q       <= row_d;
      col_q       <= col_d;
      underflow_q <= underflow_d;
      sof_err_q   <= sof_err_d;
    end
  end

  assign in_ready  = ready_c && !reset;
  assign vs_no     = vs_no_q;
  assign hs_no     = hs_no_q;
  assign blank_no  = blank_no_q;
  assign output_R  = r_q;
  assign output_G  = g_q;
  assign output_B  = b_q;
  assign row       = row_q;
  assign col       = col_q;
  assign underflow = underflow_q;
  assign sof_err   = sof_err_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_raster_timing_gen.sv
// tb_raster_timing_gen: directed, table-driven bench for raster_timing_gen
// using a 4x2 active raster (H_TOTAL=8, V_TOTAL=5, 40 clocks per frame).
module tb_raster_timing_gen;
  import raster_pkg::*;

  localparam int CW = 13;
  localparam int HT = 8;
  localparam int VT = 5;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic          in_valid = 1'b0, in_sof = 1'b0, clear_err = 1'b0;
  logic [7:0]    in_R = '0, in_G = '0, in_B = '0;
  logic          in_ready, vs_no, hs_no, blank_no, underflow, sof_err;
  logic [7:0]    output_R, output_G, output_B;
  logic [CW-1:0] row, col;
  state_t        state_dbg;
`ifdef RASTER_TEST_PATTERN_EN
  logic          pattern_en = 1'b0;
`endif

  raster_timing_gen #(
    .WIDTH(4), .HEIGHT(2), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_FP(1), .V_SYNC(1), .V_BP(1), .PIXEL_DEPTH(8), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_sof(in_sof),
    .in_R(in_R), .in_G(in_G), .in_B(in_B),
`ifdef RASTER_TEST_PATTERN_EN
    .pattern_en(pattern_en),
`endif
    .vs_no(vs_no), .hs_no(hs_no), .blank_no(blank_no),
    .output_R(output_R), .output_G(output_G), .output_B(output_B),
    .row(row), .col(col),
    .underflow(underflow), .sof_err(sof_err), .clear_err(clear_err),
    .state_dbg(state_dbg)
  );

  // ---------------- scoreboard counters ----------------
  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;   // clocks since reset release = raster position before the edge

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  // Channel derivation so R/G/B swaps or stuck channels are visible.
  function automatic logic [23:0] exp_rgb(input logic [7:0] r);
    if (r == 8'd0) return 24'd0;
    return {r, r ^ 8'h5A, r + 8'h33};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input logic v, input logic s, input logic [7:0] p, input logic c);
    in_valid  = v;
    in_sof    = s;
    in_R      = p;
    in_G      = p ^ 8'h5A;
    in_B      = p + 8'h33;
    clear_err = c;
  endtask

  task automatic edge_sample();
    @(posedge clk);
    #1;
  endtask

  // Outputs after the edge describe raster position pos.
  task automatic check_timing(input int pos);
    int p, r, c;
    p = pos % (HT * VT);
    r = p / HT;
    c = p % HT;
    check("row_col", 32'({row, col}), 32'({CW'(r), CW'(c)}));
    check("hs_no", 32'(hs_no), 32'(!(c == 5 || c == 6)));
    check("vs_no", 32'(vs_no), 32'(r != 3));
  endtask

  // Cycles where no pixel may be taken and the output must be blank.
  task automatic idle(input int n, input logic v, input logic s, input logic [7:0] p);
    for (int i = 0; i < n; i++) begin
      drive(v, s, p, 1'b0);
      #1;
      check("idle_ready", 32'(in_ready), 32'd0);
      edge_sample();
      check_timing(cyc);
      check("idle_blank", 32'(blank_no), 32'd0);
      check("idle_rgb", 32'({output_R, output_G, output_B}), 32'd0);
      cyc++;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(1'b0, 1'b0, 8'd0, 1'b0);
    edge_sample();
    edge_sample();
    reset = 1'b0;
    cyc = 0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic       v, s;
    logic [7:0] p;
    logic       c;
    logic       rdy, bl;
    logic [7:0] r;
    logic       uf, se;
  } vec_t;

  vec_t vecs[57];

  function automatic vec_t mk(input int v, input int s, input int p, input int c,
                              input int rdy, input int bl, input int r,
                              input int uf, input int se);
    vec_t m;
    m.v = 1'(v); m.s = 1'(s); m.p = 8'(p); m.c = 1'(c);
    m.rdy = 1'(rdy); m.bl = 1'(bl); m.r = 8'(r); m.uf = 1'(uf); m.se = 1'(se);
    return m;
  endfunction

  task automatic apply_vecs(input int first, input int last);
    for (int i = first; i <= last; i++) begin
      drive(vecs[i].v, vecs[i].s, vecs[i].p, vecs[i].c);
      #1;
      check("vec_ready", 32'(in_ready), 32'(vecs[i].rdy));
      edge_sample();
      check_timing(cyc);
      check("vec_blank", 32'(blank_no), 32'(vecs[i].bl));
      check("vec_rgb", 32'({output_R, output_G, output_B}), 32'(exp_rgb(vecs[i].r)));
      check("vec_underflow", 32'(underflow), 32'(vecs[i].uf));
      check("vec_sof_err", 32'(sof_err), 32'(vecs[i].se));
      cyc++;
    end
  endtask

  initial begin
    // Frame A: pixels 1..8, head 9 waits in the vertical blank.
    for (int i = 0; i < 4; i++) vecs[i] = mk(1, i == 0, i + 1, 0, 1, 1, i + 1, 0, 0);
    for (int i = 4; i < 8; i++) vecs[i] = mk(1, 0, 5, 0, 0, 0, 0, 0, 0);
    for (int i = 8; i < 12; i++) vecs[i] = mk(1, 0, i - 3, 0, 1, 1, i - 3, 0, 0);
    for (int i = 12; i < 16; i++) vecs[i] = mk(1, 1, 9, 0, 0, 0, 0, 0, 0);
    // Frame B: drop at (row 1, col 2), then clear_err.
    for (int i = 0; i < 4; i++) vecs[16+i] = mk(1, i == 0, 9 + i, 0, 1, 1, 9 + i, 0, 0);
    for (int i = 20; i < 24; i++) vecs[i] = mk(1, 0, 13, 0, 0, 0, 0, 0, 0);
    vecs[24] = mk(1, 0, 13, 0, 1, 1, 13, 0, 0);
    vecs[25] = mk(1, 0, 14, 0, 1, 1, 14, 0, 0);
    vecs[26] = mk(0, 0, 0, 0, 1, 1, 0, 1, 0);
    vecs[27] = mk(1, 0, 15, 0, 1, 1, 15, 1, 0);
    vecs[28] = mk(1, 0, 16, 1, 0, 0, 0, 0, 0);
    for (int i = 29; i < 32; i++) vecs[i] = mk(1, 0, 16, 0, 0, 0, 0, 0, 0);
    // Frame C: no sof at (0,0) is fine; sof at (row 0, col 2) is an error.
    vecs[32] = mk(1, 0, 16, 0, 1, 1, 16, 0, 0);
    vecs[33] = mk(1, 0, 17, 0, 1, 1, 17, 0, 0);
    for (int i = 34; i < 48; i++) vecs[i] = mk(1, 1, 18, 0, 0, 0, 0, 0, 1);
    // Frame D: relock, clear coinciding with an underflow, then clear.
    vecs[48] = mk(1, 1, 18, 0, 1, 1, 18, 0, 1);
    vecs[49] = mk(1, 0, 19, 0, 1, 1, 19, 0, 1);
    vecs[50] = mk(0, 0, 0, 1, 1, 1, 0, 1, 0);
    vecs[51] = mk(1, 0, 20, 0, 1, 1, 20, 1, 0);
    vecs[52] = mk(1, 0, 21, 1, 0, 0, 0, 0, 0);
    for (int i = 53; i < 56; i++) vecs[i] = mk(1, 0, 21, 0, 0, 0, 0, 0, 0);
    vecs[56] = mk(0, 0, 0, 0, 1, 1, 0, 1, 0);

    // ---- reset values (valid non-sof pixel offered to show in_ready gating) ----
    reset = 1'b1;
    drive(1'b1, 1'b0, 8'd5, 1'b0);
    edge_sample();
    check("rst_ready", 32'(in_ready), 32'd0);
    check("rst_sync_blank", 32'({vs_no, hs_no, blank_no}), 32'b110);
    check("rst_rgb", 32'({output_R, output_G, output_B}), 32'd0);
    check("rst_row_col", 32'({row, col}), 32'd0);
    check("rst_flags", 32'({underflow, sof_err}), 32'd0);
    check("rst_state", 32'(state_dbg), 32'(WAIT_SOF));
    do_reset();

    // ---- 1: free-running blank raster, two frames ----
    idle(80, 1'b0, 1'b0, 8'd0);

    // ---- 2..4: lock, stream, underflow, sof error, relock ----
    idle(40, 1'b1, 1'b1, 8'd1);
    check("lock_state", 32'(state_dbg), 32'(RUN));
    apply_vecs(0, 15);
    idle(24, 1'b1, 1'b1, 8'd9);
    apply_vecs(16, 31);
    idle(24, 1'b1, 1'b0, 8'd16);
    apply_vecs(32, 47);
    check("sof_err_state", 32'(state_dbg), 32'(WAIT_SOF));
    idle(24, 1'b1, 1'b1, 8'd18);
    apply_vecs(48, 56);

    // ---- 5: reset at (row 1, col 1) in RUN ----
    reset = 1'b1;
    drive(1'b1, 1'b0, 8'd22, 1'b0);
    #1;
    check("mid_rst_ready_in", 32'(in_ready), 32'd0);
    edge_sample();
    check("mid_rst_ready", 32'(in_ready), 32'd0);
    check("mid_rst_sync_blank", 32'({vs_no, hs_no, blank_no}), 32'b110);
    check("mid_rst_rgb", 32'({output_R, output_G, output_B}), 32'd0);
    check("mid_rst_row_col", 32'({row, col}), 32'd0);
    check("mid_rst_flags", 32'({underflow, sof_err}), 32'd0);
    check("mid_rst_state", 32'(state_dbg), 32'(WAIT_SOF));
    reset = 1'b0;
    cyc = 0;
    #1;
    check("post_rst_drain_ready", 32'(in_ready), 32'd1);
    edge_sample();
    check_timing(cyc);
    check("post_rst_blank", 32'(blank_no), 32'd0);
    cyc++;

`ifdef RASTER_TEST_PATTERN_EN
    // ---- 6: colour bars ----
    begin
      logic [23:0] bars [4];
      bars[0] = 24'hFFFFFF; bars[1] = 24'h00FFFF; bars[2] = 24'hFF00FF; bars[3] = 24'h0000FF;
      do_reset();
      pattern_en = 1'b1;
      idle(40, 1'b1, 1'b1, 8'd1);
      for (int c = 0; c < 8; c++) begin
        drive(1'b1, 1'b1, 8'd1, 1'b0);
        #1;
        check("pat_ready", 32'(in_ready), 32'd0);
        edge_sample();
        check_timing(cyc);
        check("pat_blank", 32'(blank_no), 32'(c < 4));
        check("pat_rgb", 32'({output_R, output_G, output_B}), 32'(c < 4 ? bars[c] : 24'd0));
        check("pat_underflow", 32'(underflow), 32'd0);
        cyc++;
      end
      pattern_en = 1'b0;
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
